phase_xform_buffer: RTL and testbench

Parametrised successor to the 4-entry counter-phased transform store. Accepts a stream of data words over a valid/ready handshake. Transforms each word by an operation chosen from the current beat-count phase and write index, stores the result in a DEPTH-entry circular array, and streams it out with backpressure. An independent registered read port inspects stored entries. It sits between the stimulus driver and the checker in the concolic test fabric.

---
 rtl/phase_xform_pkg.sv | 11 +
 rtl/phase_xform_alu.sv | 20 ++
 rtl/phase_xform_buffer.sv | 80 ++++++++
 tb/tb_phase_xform_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_xform_pkg.sv
// phase_xform_pkg: phase and operation encodings shared by the transform buffer and its ALU.
package phase_xform_pkg;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  typedef enum logic [2:0] {OP_MOD, OP_SQR, OP_HALF, OP_SHR2, OP_ZERO} op_t;
  function automatic phase_t phase_of(input int unsigned c, t1, t2, t3);
    return c < t1 ? PH0 : c < t2 ? PH1 : c < t3 ? PH2 : PH3;
  endfunction
  function automatic op_t op_of(input phase_t ph, input logic odd);
    return ph == PH0 ? (odd ? OP_SQR : OP_MOD) : ph == PH1 ? OP_HALF : ph == PH2 ? OP_SHR2 : OP_ZERO;
  endfunction
endpackage

// File: rtl/phase_xform_alu.sv
// phase_xform_alu: combinational transform of one word, selected by phase and write-index parity.
module phase_xform_alu import phase_xform_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int MOD_K  = 5
) (
  input  logic [1:0]        phase,
  input  logic              idx0,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] result
);
  op_t op;
  logic [DATA_W-1:0] sq;
  assign op = op_of(phase_t'(phase), idx0);
  assign sq = d * d;
  always_comb
    result = op == OP_MOD  ? d % DATA_W'(MOD_K) :
             op == OP_SQR  ? sq :
             op == OP_HALF ? d / DATA_W'(2) :
             op == OP_SHR2 ? d >> 2 : '0;
endmodule

// File: rtl/phase_xform_buffer.sv
// phase_xform_buffer: two-stage valid/ready pipeline that transforms words by beat phase and stores them in a circular array.
module phase_xform_buffer import phase_xform_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int T1      = 1,
  parameter int T2      = 128,
  parameter int T3      = 192,
  parameter int MOD_K   = 5,
  parameter int CNT_SAT = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_idx,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  cnt
);
  logic              a_valid, accept, b_accept, b_fire;
  logic [DATA_W-1:0] a_data, result;
  logic [CNT_W-1:0]  a_cnt, cnt_next;
  logic [AW-1:0]     a_idx, wr_ptr;
  logic [1:0]        a_phase;
  logic [DATA_W-1:0] mem [DEPTH];
  assign b_accept = !out_valid || out_ready;
  assign in_ready = !a_valid || b_accept;
  assign accept   = in_valid && in_ready;
  assign b_fire   = a_valid && b_accept;
  assign cnt_next = (CNT_SAT != 0 && &cnt) ? cnt : cnt + CNT_W'(1);
  assign a_phase  = phase_of(32'(a_cnt), T1, T2, T3);
  phase_xform_alu #(.DATA_W(DATA_W), .MOD_K(MOD_K)) u_alu (
    .phase(a_phase), .idx0(a_idx[0]), .d(a_data), .result(result)
  );
  // The read port samples before any same-edge write, so it sees the old entry.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt       <= '0;
      wr_ptr    <= '0;
      a_valid   <= 1'b0;
      a_data    <= '0;
      a_cnt     <= '0;
      a_idx     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      rd_data   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (clr) begin
        cnt       <= '0;
        wr_ptr    <= '0;
        a_valid   <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          a_data <= in_data;
          a_cnt  <= cnt;
          a_idx  <= wr_ptr;
          cnt    <= cnt_next;
          wr_ptr <= wr_ptr + AW'(1);
        end
        a_valid <= accept || (a_valid && !b_fire);
        if (b_fire) begin
          mem[a_idx] <= result;
          out_data   <= result;
          out_idx    <= a_idx;
        end
        out_valid <= b_fire || (out_valid && !out_ready);
      end
    end
endmodule

// File: tb/tb_phase_xform_buffer.sv
// tb_phase_xform_buffer: three configurations (default, T1=4, saturating counter) against a per-beat reference model.
module tb_phase_xform_buffer;
  logic clk = 0, reset = 1, clr = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic [1:0]  rd_addr = 0;
  logic        in_ready [3], out_valid [3];
  logic [31:0] out_data [3], rd_data [3];
  logic [1:0]  out_idx [3];
  logic [7:0]  cnt [3];

  always #5 clk = ~clk;

  phase_xform_buffer u0 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_idx(out_idx[0]), .rd_addr(rd_addr), .rd_data(rd_data[0]), .cnt(cnt[0]));
  phase_xform_buffer #(.T1(4)) u1 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_idx(out_idx[1]), .rd_addr(rd_addr), .rd_data(rd_data[1]), .cnt(cnt[1]));
  phase_xform_buffer #(.CNT_SAT(1)) u2 (.clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
    .out_idx(out_idx[2]), .rd_addr(rd_addr), .rd_data(rd_data[2]), .cnt(cnt[2]));

  typedef struct packed {logic [31:0] d; logic [1:0] i;} beat_t;
  typedef struct {logic [31:0] din; logic [31:0] e0; logic [31:0] e1; logic [1:0] idx;} vec_t;
  beat_t       q [3][$];
  beat_t       got [3][$];
  logic [31:0] mm [3][4];
  int unsigned n [3] = '{0, 0, 0};
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, a, e);
    end
  endtask

  // Reference: the n-th beat since reset/clr, judged directly from the phase rules.
  function automatic logic [31:0] model(input int k, input int unsigned nn, input logic [31:0] d);
    int unsigned c  = (k == 2) ? (nn > 255 ? 255 : nn) : nn % 256;
    int unsigned t1 = (k == 1) ? 4 : 1;
    logic [31:0] sq = d * d;
    if (c < t1) return (nn % 2 == 0) ? d % 5 : sq;
    if (c < 128) return d / 2;
    if (c < 192) return d >> 2;
    return 0;
  endfunction

  function automatic logic [31:0] cnt_model(input int k, input int unsigned nn);
    return (k == 2) ? (nn > 255 ? 255 : nn) : nn % 256;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    logic [31:0] r;
    for (int k = 0; k < 3; k++) begin
      if (!reset || clr) begin
        q[k].delete();
        n[k] = 0;
        if (!reset) for (int a = 0; a < 4; a++) mm[k][a] = 0;
      end else begin
        chk($sformatf("cnt u%0d", k), 32'(cnt[k]), cnt_model(k, n[k]));
        if (out_valid[k] && out_ready) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra beat u%0d: got %h, want none", k, out_data[k]);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("out_data u%0d", k), out_data[k], e.d);
            chk($sformatf("out_idx u%0d", k), 32'(out_idx[k]), 32'(e.i));
            got[k].push_back({out_data[k], out_idx[k]});
          end
        end
        if (in_valid && in_ready[k]) begin
          r = model(k, n[k], in_data);
          q[k].push_back('{d: r, i: 2'(n[k] % 4)});
          mm[k][n[k] % 4] = r;
          n[k]++;
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 0;
    clr = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    for (int k = 0; k < 3; k++) got[k].delete();
  endtask

  task automatic push(input logic [31:0] d);
    int t = 0;
    logic ok;
    in_valid = 1;
    in_data = d;
    do begin
      @(negedge clk);
      ok = in_ready[0];
      @(posedge clk);
      #1 t++;
    end while (!ok && t < 50);
    chk("push accepted", 32'(ok), 1);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 0;
    out_ready = 1;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    chk("drain", q[0].size() + q[1].size() + q[2].size(), 0);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("%s rd u%0d[%0d]", tag, k, a), rd_data[k], mm[k][a]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [8];
    int acc;
    logic ok;
    logic [31:0] d;
    tv = '{'{7, 2, 2, 0}, '{3, 1, 9, 1}, '{10, 5, 0, 2}, '{9, 4, 81, 3},
           '{6, 1, 1, 0}, '{6, 3, 36, 1}, '{6, 3, 1, 2}, '{6, 3, 36, 3}};
    #1;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      out_ready = 1;
      for (int i = 0; i < 4; i++) push(tv[4*s+i].din);
      drain();
      chk("table count", got[0].size(), 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tv%0d u0 data", 4*s+i), got[0][i].d, tv[4*s+i].e0);
        chk($sformatf("tv%0d u0 idx", 4*s+i), 32'(got[0][i].i), 32'(tv[4*s+i].idx));
        chk($sformatf("tv%0d u1 data", 4*s+i), got[1][i].d, tv[4*s+i].e1);
        chk($sformatf("tv%0d u2 data", 4*s+i), got[2][i].d, tv[4*s+i].e0);
      end
      for (int a = 0; a < 4; a++) begin
        rd_addr = 2'(a);
        @(posedge clk);
        #1;
        chk($sformatf("tv rd u0[%0d]", a), rd_data[0], tv[4*s+a].e0);
        chk($sformatf("tv rd u1[%0d]", a), rd_data[1], tv[4*s+a].e1);
      end
    end
    // read-during-write at index 0: old value first, new value one cycle later
    rd_addr = 0;
    push(20);
    in_valid = 0;
    @(posedge clk);
    #1 chk("rdw old", rd_data[0], 1);
    @(posedge clk);
    #1 chk("rdw new", rd_data[0], 10);
    drain();

    do_reset();
    for (int i = 0; i < 257; i++) push(32'h100);
    drain();
    chk("beat127", got[0][127].d, 32'h80);
    chk("beat128", got[0][128].d, 32'h40);
    chk("beat191", got[0][191].d, 32'h40);
    chk("beat192", got[0][192].d, 0);
    chk("beat256 wrap", got[0][256].d, 1);
    chk("beat256 wrap idx", 32'(got[0][256].i), 0);
    chk("beat256 sat", got[2][256].d, 0);
    chk("cnt wrap", 32'(cnt[0]), 1);
    chk("cnt sat", 32'(cnt[2]), 255);

    do_reset();
    out_ready = 0;
    acc = 0;
    d = 101;
    in_valid = 1;
    in_data = d;
    repeat (3) begin
      @(negedge clk);
      ok = in_ready[0];
      @(posedge clk);
      #1;
      if (ok) begin
        acc++;
        d++;
        in_data = d;
      end
    end
    @(negedge clk);
    chk("bp accepts", acc, 2);
    chk("bp in_ready", 32'(in_ready[0]), 0);
    chk("bp out_valid held", 32'(out_valid[0]), 1);
    chk("bp out_data held", out_data[0], 1);
    @(posedge clk);
    #1 out_ready = 1;
    for (int i = 0; i < 4; i++) push(d + 32'(i));
    drain();
    chk("bp total beats", got[0].size(), 6);
    chk("bp second beat", got[0][1].d, 51);
    chk("bp last beat", got[0][5].d, 53);

    out_ready = 0;
    push(7);
    push(8);
    in_valid = 0;
    chk("pre-reset out_valid", 32'(out_valid[0]), 1);
    reset = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async in_ready u%0d", k), 32'(in_ready[k]), 1);
      chk($sformatf("async out_valid u%0d", k), 32'(out_valid[k]), 0);
      chk($sformatf("async out_data u%0d", k), out_data[k], 0);
      chk($sformatf("async out_idx u%0d", k), 32'(out_idx[k]), 0);
      chk($sformatf("async rd_data u%0d", k), rd_data[k], 0);
      chk($sformatf("async cnt u%0d", k), 32'(cnt[k]), 0);
    end
    @(posedge clk);
    #1 reset = 1;
    out_ready = 1;
    sweep("after reset");

    push(11);
    push(12);
    push(13);
    in_valid = 0;
    @(posedge clk);
    #1 chk("pre-clr out_valid", 32'(out_valid[0]), 1);
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    chk("clr cnt", 32'(cnt[0]), 0);
    chk("clr out_valid", 32'(out_valid[0]), 0);
    chk("clr in_ready", 32'(in_ready[0]), 1);
    sweep("after clr");
    push(8);
    drain();
    chk("post-clr idx", 32'(got[0][got[0].size()-1].i), 0);

    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = ($urandom % 2) ? $urandom : 32'($urandom % 64);
      out_ready = ($urandom % 3) != 0;
      rd_addr   = 2'($urandom);
      @(posedge clk);
      #1;
    end
    drain();
    sweep("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
